ad9361_dual_axis_unpack: RTL

Transmit-path counterpart of the AD9361 receive packer. Accepts 128-bit AXI-stream beats, each carrying one sample for four 12-bit I/Q channels. Buffers the beats in a small FIFO and returns one sample per channel to the AD9361 DAC core on each sample request. Flags underflow and, optionally, burst-framing errors, all in a single clock domain.

---
 rtl/ad9361_dual_axis_unpack.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ad9361_dual_axis_unpack.sv
// ============================================================================
// Module      : ad9361_dual_axis_unpack
// Description : Unpacks 128-bit AXI-stream beats into four 12-bit I/Q channel
//               samples for the AD9361 DAC core, through a small beat FIFO.
//               Optional build macro AD9361_TX_UNDERFLOW_ZERO_EN zeroes the
//               data outputs on underflow instead of holding the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9361_dual_axis_unpack #(
    parameter int REVERSE_DATA      = 0,
    parameter int FIFO_DEPTH        = 8,
    parameter int USE_AXIS_TLAST    = 0,
    parameter int AXIS_BURST_LENGTH = 512
) (
    input  logic         data_clk,
    input  logic         rst,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    input  logic [127:0] s_axis_tdata,
    input  logic         dac_req,
    output logic         valid_0,
    output logic         valid_1,
    output logic         valid_2,
    output logic         valid_3,
    output logic [11:0]  data_i0,
    output logic [11:0]  data_q0,
    output logic [11:0]  data_i1,
    output logic [11:0]  data_q1,
    output logic [11:0]  data_i2,
    output logic [11:0]  data_q2,
    output logic [11:0]  data_i3,
    output logic [11:0]  data_q3,
    output logic         underflow,
    output logic [15:0]  underflow_count,
    output logic         tlast_error
);

    localparam int              c_AW   = $clog2(FIFO_DEPTH);
    localparam int              c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    logic [95:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_next;
    logic            r_tready;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [95:0]     w_beat;
    logic [95:0]     r_sample;
    logic            r_valid;
    logic            r_underflow;
    logic [15:0]     r_uf_count;
    logic            w_unused_inputs;

    // Upper lane nibbles (and tlast when unchecked) carry nothing.
    assign w_unused_inputs = ^{s_axis_tdata, s_axis_tlast};

    // Sample word order: i0 q0 i1 q1 i2 q2 i3 q3, i0 in the top 12 bits.
    for (genvar k = 0; k < 8; k++) begin : g_lane
        if (REVERSE_DATA != 0) begin : g_rev
            assign w_beat[95-12*k -: 12] = s_axis_tdata[16*k +: 12];
        end else begin : g_fwd
            assign w_beat[95-12*k -: 12] = s_axis_tdata[16*(7-k) +: 12];
        end
    end

    assign w_empty = (r_count == '0);
    assign w_push  = s_axis_tvalid & r_tready;
    assign w_pop   = dac_req & ~w_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge data_clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_tready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + c_AW'(1);
            r_count  <= w_count_next;
            r_tready <= (w_count_next != c_FULL);
        end
    end

    always_ff @(posedge data_clk) begin
        if (w_push) r_mem[r_wptr] <= w_beat;
    end

    // A beat pushed while empty is not readable until the next cycle.
    always_ff @(posedge data_clk) begin
        if (rst) begin
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
            r_uf_count  <= '0;
        end else begin
            r_valid     <= dac_req;
            r_underflow <= 1'b0;
            if (w_pop) begin
                r_sample <= r_mem[r_rptr];
            end else if (dac_req) begin
                r_underflow <= 1'b1;
                if (r_uf_count != 16'hFFFF) r_uf_count <= r_uf_count + 16'd1;
`ifdef AD9361_TX_UNDERFLOW_ZERO_EN
                r_sample <= '0;
`endif
            end
        end
    end

    if (USE_AXIS_TLAST != 0) begin : g_tlast
        localparam int              c_BW   = $clog2(AXIS_BURST_LENGTH) + 1;
        localparam logic [c_BW-1:0] c_LAST = c_BW'(AXIS_BURST_LENGTH - 1);

        logic [c_BW-1:0] r_beat_cnt;
        logic            r_err;
        logic            w_at_last;

        assign w_at_last = (r_beat_cnt == c_LAST);

        always_ff @(posedge data_clk) begin
            if (rst) begin
                r_beat_cnt <= '0;
                r_err      <= 1'b0;
            end else begin
                r_err <= 1'b0;
                if (w_push) begin
                    r_err <= s_axis_tlast ^ w_at_last;
                    if (s_axis_tlast || w_at_last) r_beat_cnt <= '0;
                    else                           r_beat_cnt <= r_beat_cnt + c_BW'(1);
                end
            end
        end

        assign tlast_error = r_err;
    end else begin : g_no_tlast
        assign tlast_error = 1'b0;
    end

    assign s_axis_tready   = r_tready;
    assign valid_0         = r_valid;
    assign valid_1         = r_valid;
    assign valid_2         = r_valid;
    assign valid_3         = r_valid;
    assign data_i0         = r_sample[95:84];
    assign data_q0         = r_sample[83:72];
    assign data_i1         = r_sample[71:60];
    assign data_q1         = r_sample[59:48];
    assign data_i2         = r_sample[47:36];
    assign data_q2         = r_sample[35:24];
    assign data_i3         = r_sample[23:12];
    assign data_q3         = r_sample[11:0];
    assign underflow       = r_underflow;
    assign underflow_count = r_uf_count;

endmodule

`default_nettype wire
